// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- load/store unit controller between the MEM stage and a
// word-wide SRAM port with request/grant and read-valid handshakes.
//
// A request is accepted in IDLE and registered. It is then issued as one
// word-aligned SRAM phase. If it crosses a word boundary, a second phase is
// issued at the next word. Stores are lane-shifted with byte strobes. Loads
// are shifted down, trimmed to the access size and sign/zero-extended. The
// result is reported with a one-cycle resp_valid pulse.
//
// Configuration macro:
//   LSU_MISALIGN_SPLIT_EN  defined   : word-crossing accesses run as two
//                                      SRAM phases, resp_err = 0.
//                          undefined : word-crossing accesses go straight
//                                      to RESP with resp_err = 1 and no
//                                      SRAM traffic.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid / req_ready         request handshake (ready only in IDLE)
//   req_we, req_mode, req_us      store flag, one-hot size, zero-extend flag
//   req_addr, req_wdata           byte address, right-justified store data
//   resp_valid, resp_rdata        completion pulse, extended load data
//   resp_err                      misaligned-access fault
//   sram_req / sram_gnt           SRAM request handshake
//   sram_addr, sram_wstrb         word address, byte strobes (0 for reads)
//   sram_wdata                    lane-aligned store data
//   sram_rvalid, sram_rdata       read data / write acknowledge
// -----------------------------------------------------------------------------
module lsu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_mode,
  input  logic        req_us,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        sram_req,
  input  logic        sram_gnt,
  output logic [3:0]  sram_wstrb,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic        sram_rvalid,
  input  logic [31:0] sram_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    WAIT_LO = 3'd2,
    REQ_HI  = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t state;

  // Captured request attributes.
  logic        we_q;
  logic        us_q;
  logic        split_q;
  logic [1:0]  off_q;
  logic [2:0]  size_q;
  logic [31:0] hi_addr_q;
  logic [31:0] hi_wdata_q;
  logic [3:0]  hi_wstrb_q;
  logic [31:0] lo_word_q;

  // Decode of the incoming request, used only on the accept cycle.
  logic [2:0]  size_in;
  logic [3:0]  mask4_in;
  logic [1:0]  off_in;
  logic        mis_in;
  logic [63:0] st_data_in;
  logic [7:0]  st_mask_in;
  logic [31:0] lo_addr_in;

  // NOTE: every signal driven from always_comb gets a default at the top of
  // the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    size_in  = 3'd4;
    mask4_in = 4'b1111;
    case (req_mode)
      3'b001: begin size_in = 3'd1; mask4_in = 4'b0001; end
      3'b010: begin size_in = 3'd2; mask4_in = 4'b0011; end
      default: ;
    endcase
    off_in     = req_addr[1:0];
    mis_in     = ({1'b0, off_in} + size_in) > 3'd4;
    st_data_in = {32'b0, req_wdata} << {off_in, 3'b000};
    st_mask_in = {4'b0, mask4_in} << off_in;
    lo_addr_in = {req_addr[31:2], 2'b00};
  end

  // Load return path. The final word arrives either in WAIT_LO (single
  // phase, hi word is zero) or in WAIT_HI (lo word already captured).
  logic [63:0] ld_cat;
  logic [31:0] ld_win;
  logic [31:0] ld_ext;

  always_comb begin
    ld_cat = (state == WAIT_HI) ? {sram_rdata, lo_word_q} : {32'b0, sram_rdata};
    ld_win = 32'(ld_cat >> {off_q, 3'b000});
    ld_ext = ld_win;
    case (size_q)
      3'd1:    ld_ext = us_q ? {24'b0, ld_win[7:0]}  : {{24{ld_win[7]}}, ld_win[7:0]};
      3'd2:    ld_ext = us_q ? {16'b0, ld_win[15:0]} : {{16{ld_win[15]}}, ld_win[15:0]};
      default: ld_ext = ld_win;
    endcase
  end

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      sram_req   <= 1'b0;
      sram_addr  <= '0;
      sram_wstrb <= '0;
      sram_wdata <= '0;
      we_q       <= 1'b0;
      us_q       <= 1'b0;
      split_q    <= 1'b0;
      off_q      <= '0;
      size_q     <= 3'd1;
      hi_addr_q  <= '0;
      hi_wdata_q <= '0;
      hi_wstrb_q <= '0;
      lo_word_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            us_q      <= req_us;
            off_q     <= off_in;
            size_q    <= size_in;
            req_ready <= 1'b0;
            if (mis_in && !SPLIT_EN) begin
              // Faulting access: report immediately, never touch the SRAM.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state      <= REQ_LO;
              split_q    <= mis_in && SPLIT_EN;
              sram_req   <= 1'b1;
              sram_addr  <= lo_addr_in;
              sram_wstrb <= req_we ? st_mask_in[3:0]  : 4'b0;
              sram_wdata <= req_we ? st_data_in[31:0] : 32'b0;
              // High phase is staged now so the request inputs may change.
              hi_addr_q  <= lo_addr_in + 32'd4;
              hi_wstrb_q <= req_we ? st_mask_in[7:4]   : 4'b0;
              hi_wdata_q <= req_we ? st_data_in[63:32] : 32'b0;
            end
          end
        end

        REQ_LO, REQ_HI: begin
          if (sram_gnt) begin
            state      <= (state == REQ_LO) ? WAIT_LO : WAIT_HI;
            sram_req   <= 1'b0;
            sram_addr  <= '0;
            sram_wstrb <= '0;
            sram_wdata <= '0;
          end
        end

        WAIT_LO: begin
          if (sram_rvalid) begin
            lo_word_q <= sram_rdata;
            if (split_q) begin
              state      <= REQ_HI;
              sram_req   <= 1'b1;
              sram_addr  <= hi_addr_q;
              sram_wstrb <= hi_wstrb_q;
              sram_wdata <= hi_wdata_q;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= we_q ? 32'b0 : ld_ext;
            end
          end
        end

        WAIT_HI: begin
          if (sram_rvalid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= we_q ? 32'b0 : ld_ext;
          end
        end

        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end

        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          sram_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- directed self-checking bench for lsu_ctrl. Inputs are driven
// and outputs sampled on the falling clock edge; the DUT registers on the
// rising edge. The cycle numbering follows the request being accepted at
// the rising edge that ends cycle 0.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_mode;
  logic        req_us;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        sram_req;
  logic        sram_gnt;
  logic [3:0]  sram_wstrb;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_rvalid;
  logic [31:0] sram_rdata;

  int n_checks;
  int n_fail;

  lsu_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_mode    (req_mode),
    .req_us      (req_us),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .sram_req    (sram_req),
    .sram_gnt    (sram_gnt),
    .sram_wstrb  (sram_wstrb),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_rvalid (sram_rvalid),
    .sram_rdata  (sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  localparam logic [2:0] M_B = 3'b001;
  localparam logic [2:0] M_H = 3'b010;
  localparam logic [2:0] M_W = 3'b100;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  mode;
    logic        us;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
  } ld_vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  mode;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [2:0]  gnt_delay;
  } st_vec_t;

  // Request outputs seen while a phase is pending: {sram_req, resp_valid,
  // req_ready, sram_addr, sram_wstrb, sram_wdata}.
  logic [70:0] got_req;
  logic [70:0] exp_req;
  // Response outputs: {resp_valid, resp_err, req_ready, resp_rdata}.
  logic [34:0] got_resp;
  logic [34:0] exp_resp;

  task automatic drive_req(input logic we, input logic [2:0] mode, input logic us,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_mode  = mode;
    req_us    = us;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // Scribble over the request inputs to show they are no longer observed.
  task automatic scramble_req();
    req_valid = 1'b0;
    req_we    = ~req_we;
    req_mode  = 3'b010;
    req_us    = ~req_us;
    req_addr  = 32'hDEAD_BEE1;
    req_wdata = 32'h5A5A_A5A5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_err, sram_req} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready/rv/err/req=%b want 1000",
               {req_ready, resp_valid, resp_err, sram_req});
    end
    n_checks++;
    if ({resp_rdata, sram_addr, sram_wstrb, sram_wdata} !== 100'b0) begin
      n_fail++;
      $display("FAIL reset_data: got rdata=%h addr=%h wstrb=%b wdata=%h want all zero",
               resp_rdata, sram_addr, sram_wstrb, sram_wdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({req_ready, sram_req, resp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got ready/req/rv=%b want 100",
               {req_ready, sram_req, resp_valid});
    end
  endtask

  task automatic test_aligned_loads();
    ld_vec_t v [0:5];
    v[0] = '{32'h0000_1003, M_B, 1'b0, 32'h8011_2233, 32'h0000_1000, 32'hFFFF_FF80};
    v[1] = '{32'h0000_1003, M_B, 1'b1, 32'h8011_2233, 32'h0000_1000, 32'h0000_0080};
    v[2] = '{32'h0000_1002, M_H, 1'b0, 32'h8011_2233, 32'h0000_1000, 32'hFFFF_8011};
    v[3] = '{32'h0000_1000, M_H, 1'b1, 32'h8011_8234, 32'h0000_1000, 32'h0000_8234};
    v[4] = '{32'h0000_1004, M_W, 1'b0, 32'hDEAD_BEEF, 32'h0000_1004, 32'hDEAD_BEEF};
    v[5] = '{32'h0000_1001, M_B, 1'b0, 32'h1234_5678, 32'h0000_1000, 32'h0000_0056};
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b0, v[i].mode, v[i].us, v[i].addr, 32'hFFFF_FFFF);
      @(negedge clk);                       // cycle 1: phase issued
      scramble_req();
      got_req = {sram_req, resp_valid, req_ready, sram_addr, sram_wstrb, sram_wdata};
      exp_req = {1'b1, 1'b0, 1'b0, v[i].exp_addr, 4'b0000, 32'h0};
      n_checks++;
      if (got_req !== exp_req) begin
        n_fail++;
        $display("FAIL load%0d_issue: got %h want %h", i, got_req, exp_req);
      end
      sram_gnt = 1'b1;
      @(negedge clk);                       // cycle 2: waiting for data
      sram_gnt    = 1'b0;
      sram_rvalid = 1'b1;
      sram_rdata  = v[i].rdata;
      n_checks++;
      if ({sram_req, resp_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL load%0d_wait: got req/rv=%b want 00", i, {sram_req, resp_valid});
      end
      @(negedge clk);                       // cycle 3: response
      sram_rvalid = 1'b0;
      sram_rdata  = 32'h0;
      got_resp = {resp_valid, resp_err, req_ready, resp_rdata};
      exp_resp = {1'b1, 1'b0, 1'b0, v[i].exp_rdata};
      n_checks++;
      if (got_resp !== exp_resp) begin
        n_fail++;
        $display("FAIL load%0d_resp: got %h want %h", i, got_resp, exp_resp);
      end
      @(negedge clk);                       // cycle 4: back to idle
      n_checks++;
      if ({resp_valid, req_ready, sram_req} !== 3'b010) begin
        n_fail++;
        $display("FAIL load%0d_idle: got rv/ready/req=%b want 010", i,
                 {resp_valid, req_ready, sram_req});
      end
    end
  endtask

  task automatic test_aligned_stores();
    st_vec_t v [0:3];
    v[0] = '{32'h0000_2002, M_H, 32'h0000_BEEF, 32'h0000_2000, 4'b1100, 32'hBEEF_0000, 3'd0};
    v[1] = '{32'h0000_2001, M_B, 32'h0000_00A5, 32'h0000_2000, 4'b0010, 32'h0000_A500, 3'd2};
    v[2] = '{32'h0000_2008, M_W, 32'hCAFE_F00D, 32'h0000_2008, 4'b1111, 32'hCAFE_F00D, 3'd1};
    v[3] = '{32'h0000_200B, M_B, 32'hFFFF_FF77, 32'h0000_2008, 4'b1000, 32'h7700_0000, 3'd0};
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b1, v[i].mode, 1'b0, v[i].addr, v[i].wdata);
      @(negedge clk);
      scramble_req();
      for (int k = 0; k <= int'(v[i].gnt_delay); k++) begin
        got_req = {sram_req, resp_valid, req_ready, sram_addr, sram_wstrb, sram_wdata};
        exp_req = {1'b1, 1'b0, 1'b0, v[i].exp_addr, v[i].exp_wstrb, v[i].exp_wdata};
        n_checks++;
        if (got_req !== exp_req) begin
          n_fail++;
          $display("FAIL store%0d_issue_c%0d: got %h want %h", i, k, got_req, exp_req);
        end
        sram_gnt = (k == int'(v[i].gnt_delay));
        @(negedge clk);
      end
      sram_gnt    = 1'b0;
      sram_rvalid = 1'b1;
      sram_rdata  = 32'hFFFF_FFFF;          // must not leak into resp_rdata
      n_checks++;
      if ({sram_req, resp_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL store%0d_wait: got req/rv=%b want 00", i, {sram_req, resp_valid});
      end
      @(negedge clk);
      sram_rvalid = 1'b0;
      got_resp = {resp_valid, resp_err, req_ready, resp_rdata};
      exp_resp = {1'b1, 1'b0, 1'b0, 32'h0};
      n_checks++;
      if (got_resp !== exp_resp) begin
        n_fail++;
        $display("FAIL store%0d_resp: got %h want %h", i, got_resp, exp_resp);
      end
      @(negedge clk);
      n_checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL store%0d_idle: got rv/ready=%b want 01", i, {resp_valid, req_ready});
      end
    end
  endtask

  task automatic test_back_to_back();
    drive_req(1'b0, M_W, 1'b0, 32'h0000_6000, 32'h0);
    @(negedge clk);                         // cycle 1
    n_checks++;
    if ({sram_req, sram_addr} !== {1'b1, 32'h0000_6000}) begin
      n_fail++;
      $display("FAIL b2b_first_issue: got req=%b addr=%h want 1 00006000", sram_req, sram_addr);
    end
    req_addr = 32'h0000_6004;               // req_valid stays high
    sram_gnt = 1'b1;
    @(negedge clk);                         // cycle 2
    sram_gnt    = 1'b0;
    sram_rvalid = 1'b1;
    sram_rdata  = 32'h0102_0304;
    @(negedge clk);                         // cycle 3
    sram_rvalid = 1'b0;
    got_resp = {resp_valid, resp_err, req_ready, resp_rdata};
    exp_resp = {1'b1, 1'b0, 1'b0, 32'h0102_0304};
    n_checks++;
    if (got_resp !== exp_resp) begin
      n_fail++;
      $display("FAIL b2b_first_resp: got %h want %h", got_resp, exp_resp);
    end
    @(negedge clk);                         // cycle 4: idle, accepts second
    n_checks++;
    if ({req_ready, resp_valid, sram_req} !== 3'b100) begin
      n_fail++;
      $display("FAIL b2b_idle: got ready/rv/req=%b want 100", {req_ready, resp_valid, sram_req});
    end
    @(negedge clk);                         // cycle 5
    req_valid = 1'b0;
    n_checks++;
    if ({sram_req, req_ready, sram_addr} !== {1'b1, 1'b0, 32'h0000_6004}) begin
      n_fail++;
      $display("FAIL b2b_second_issue: got req=%b ready=%b addr=%h want 1 0 00006004",
               sram_req, req_ready, sram_addr);
    end
    sram_gnt = 1'b1;
    @(negedge clk);
    sram_gnt    = 1'b0;
    sram_rvalid = 1'b1;
    sram_rdata  = 32'h0A0B_0C0D;
    @(negedge clk);
    sram_rvalid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h0A0B_0C0D}) begin
      n_fail++;
      $display("FAIL b2b_second_resp: got rv=%b rdata=%h want 1 0a0b0c0d", resp_valid, resp_rdata);
    end
    @(negedge clk);
  endtask

`ifdef LSU_MISALIGN_SPLIT_EN
  task automatic test_misaligned();
    // lw at 0x3001 across two words.
    drive_req(1'b0, M_W, 1'b0, 32'h0000_3001, 32'h0);
    @(negedge clk);
    scramble_req();
    n_checks++;
    if ({sram_req, sram_addr, sram_wstrb} !== {1'b1, 32'h0000_3000, 4'b0000}) begin
      n_fail++;
      $display("FAIL split_lw_lo: got req=%b addr=%h wstrb=%b want 1 00003000 0000",
               sram_req, sram_addr, sram_wstrb);
    end
    sram_gnt = 1'b1;
    @(negedge clk);
    sram_gnt    = 1'b0;
    sram_rvalid = 1'b1;
    sram_rdata  = 32'hAABB_CCDD;
    @(negedge clk);
    sram_rvalid = 1'b0;
    n_checks++;
    if ({sram_req, resp_valid, sram_addr} !== {1'b1, 1'b0, 32'h0000_3004}) begin
      n_fail++;
      $display("FAIL split_lw_hi: got req=%b rv=%b addr=%h want 1 0 00003004",
               sram_req, resp_valid, sram_addr);
    end
    sram_gnt = 1'b1;
    @(negedge clk);
    sram_gnt    = 1'b0;
    sram_rvalid = 1'b1;
    sram_rdata  = 32'h1122_3344;
    @(negedge clk);
    sram_rvalid = 1'b0;
    got_resp = {resp_valid, resp_err, req_ready, resp_rdata};
    exp_resp = {1'b1, 1'b0, 1'b0, 32'h44AA_BBCC};
    n_checks++;
    if (got_resp !== exp_resp) begin
      n_fail++;
      $display("FAIL split_lw_resp: got %h want %h", got_resp, exp_resp);
    end
    @(negedge clk);

    // sw at 0xFFFFFFFE wrapping to address 0.
    drive_req(1'b1, M_W, 1'b0, 32'hFFFF_FFFE, 32'h1234_5678);
    @(negedge clk);
    scramble_req();
    got_req = {sram_req, resp_valid, req_ready, sram_addr, sram_wstrb, sram_wdata};
    exp_req = {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 4'b1100, 32'h5678_0000};
    n_checks++;
    if (got_req !== exp_req) begin
      n_fail++;
      $display("FAIL split_sw_lo: got %h want %h", got_req, exp_req);
    end
    sram_gnt = 1'b1;
    @(negedge clk);
    sram_gnt    = 1'b0;
    sram_rvalid = 1'b1;
    @(negedge clk);
    sram_rvalid = 1'b0;
    got_req = {sram_req, resp_valid, req_ready, sram_addr, sram_wstrb, sram_wdata};
    exp_req = {1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0011, 32'h0000_1234};
    n_checks++;
    if (got_req !== exp_req) begin
      n_fail++;
      $display("FAIL split_sw_hi: got %h want %h", got_req, exp_req);
    end
    sram_gnt = 1'b1;
    @(negedge clk);
    sram_gnt    = 1'b0;
    sram_rvalid = 1'b1;
    @(negedge clk);
    sram_rvalid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL split_sw_resp: got rv=%b err=%b rdata=%h want 1 0 0",
               resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
  endtask
`else
  task automatic test_misaligned();
    logic [31:0] addrs [0:1];
    logic [2:0]  modes [0:1];
    addrs[0] = 32'h0000_4003; modes[0] = M_H;
    addrs[1] = 32'h0000_4001; modes[1] = M_W;
    for (int i = 0; i < 2; i++) begin
      drive_req(1'b0, modes[i], 1'b0, addrs[i], 32'h0);
      @(negedge clk);                       // cycle 1: fault reported
      scramble_req();
      sram_gnt    = 1'b1;                   // stray handshakes must be ignored
      sram_rvalid = 1'b1;
      sram_rdata  = 32'h7777_7777;
      got_resp = {resp_valid, resp_err, req_ready, resp_rdata};
      exp_resp = {1'b1, 1'b1, 1'b0, 32'h0};
      n_checks++;
      if (got_resp !== exp_resp || sram_req !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign%0d_resp: got %h req=%b want %h req=0", i, got_resp,
                 sram_req, exp_resp);
      end
      @(negedge clk);
      n_checks++;
      if ({resp_valid, resp_err, req_ready, sram_req} !== 4'b0010) begin
        n_fail++;
        $display("FAIL misalign%0d_idle: got rv/err/ready/req=%b want 0010", i,
                 {resp_valid, resp_err, req_ready, sram_req});
      end
      @(negedge clk);
      sram_gnt    = 1'b0;
      sram_rvalid = 1'b0;
      n_checks++;
      if ({resp_valid, sram_req, req_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL misalign%0d_quiet: got rv/req/ready=%b want 001", i,
                 {resp_valid, sram_req, req_ready});
      end
    end
  endtask
`endif

  task automatic test_stall_reset();
    drive_req(1'b1, M_W, 1'b0, 32'h0000_5004, 32'h0BAD_F00D);
    @(negedge clk);
    scramble_req();
    for (int k = 0; k < 5; k++) begin
      got_req = {sram_req, resp_valid, req_ready, sram_addr, sram_wstrb, sram_wdata};
      exp_req = {1'b1, 1'b0, 1'b0, 32'h0000_5004, 4'b1111, 32'h0BAD_F00D};
      n_checks++;
      if (got_req !== exp_req) begin
        n_fail++;
        $display("FAIL stall_c%0d: got %h want %h", k, got_req, exp_req);
      end
      req_addr = req_addr + 32'd1;
      @(negedge clk);
    end
    sram_gnt = 1'b1;
    @(negedge clk);                         // now in WAIT_LO
    sram_gnt = 1'b0;
    n_checks++;
    if ({sram_req, resp_valid, req_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_granted: got req/rv/ready=%b want 000", {sram_req, resp_valid, req_ready});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, sram_req, resp_valid, resp_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midop_reset: got ready/req/rv/err=%b want 1000",
               {req_ready, sram_req, resp_valid, resp_err});
    end
    sram_rvalid = 1'b1;
    sram_gnt    = 1'b1;
    sram_rdata  = 32'h1357_9BDF;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({req_ready, sram_req, resp_valid, resp_rdata} !== {3'b100, 32'h0}) begin
        n_fail++;
        $display("FAIL post_reset_c%0d: got ready/req/rv=%b rdata=%h want 100 0", k,
                 {req_ready, sram_req, resp_valid}, resp_rdata);
      end
    end
    sram_rvalid = 1'b0;
    sram_gnt    = 1'b0;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_mode    = M_W;
    req_us      = 1'b0;
    req_addr    = 32'h0;
    req_wdata   = 32'h0;
    sram_gnt    = 1'b0;
    sram_rvalid = 1'b0;
    sram_rdata  = 32'h0;

    test_reset();
    test_aligned_loads();
    test_aligned_stores();
    test_back_to_back();
    test_misaligned();
    test_stall_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1: MEM-stage access request.
REQ-004 SHALL have port req_ready, output, 1: high only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-005 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_mode, input, 3: one-hot access size; bit0 = byte, bit1 = half, bit2 = word.
REQ-007 SHALL have port req_us, input, 1: 1 = zero-extend the load, 0 = sign-extend it.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, right-justified.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32: extended load data; 0 for stores.
REQ-012 SHALL have port resp_err, output, 1: misaligned-access fault, qualified by resp_valid.
REQ-013 SHALL have port sram_req, output, 1: SRAM request, held high until granted.
REQ-014 SHALL have port sram_gnt, input, 1: SRAM accepts the request this cycle.
REQ-015 SHALL have port sram_wstrb, output, 4: byte write strobes; 0000 for a read.
REQ-016 SHALL have port sram_addr, output, 32: word-aligned address, bits[1:0] = 00.
REQ-017 SHALL have port sram_wdata, output, 32: lane-aligned store data.
REQ-018 SHALL have port sram_rvalid, input, 1: read data valid, also the write acknowledge.
REQ-019 SHALL have port sram_rdata, input, 32: SRAM read word.

Function
REQ-020 SHALL register req_we, req_mode, req_us, req_addr and req_wdata on acceptance; later changes to the request inputs SHALL have no effect.
REQ-021 SHALL implement states IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI and RESP.
REQ-022 SHALL transition IDLE -> REQ_LO on acceptance.
REQ-023 SHALL transition REQ_LO -> WAIT_LO on sram_gnt.
REQ-024 SHALL transition WAIT_LO -> REQ_HI on sram_rvalid when the access is split, and WAIT_LO -> RESP on sram_rvalid otherwise.
REQ-025 SHALL transition REQ_HI -> WAIT_HI on sram_gnt, and WAIT_HI -> RESP on sram_rvalid.
REQ-026 SHALL transition RESP -> IDLE unconditionally, with resp_valid = 1 for exactly that one cycle.
REQ-027 SHALL drive sram_req = 1 only in REQ_LO and REQ_HI.
REQ-028 SHALL hold sram_addr, sram_wstrb and sram_wdata stable while sram_req = 1 and sram_gnt = 0.
REQ-029 SHALL ignore sram_rvalid in any state other than WAIT_LO or WAIT_HI, and SHALL ignore sram_gnt in any state other than REQ_LO or REQ_HI.
REQ-030 SHALL give an aligned access a minimum latency of 3 cycles: accept at cycle 0, grant at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
REQ-031 SHALL compute the access as follows: off = addr[1:0]; size = 1, 2 or 4 bytes; the access is misaligned when off + size > 4.
REQ-032 SHALL use the low phase at addr & ~3 and the high phase at (addr & ~3) + 4, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-033 SHALL form stores as 64-bit data = wdata << (8*off) and 8-bit mask = ((1 << size) - 1) << off; the low phase SHALL use bits[31:0] and mask[3:0], and the high phase SHALL use bits[63:32] and mask[7:4].
REQ-034 SHALL form loads as {hi_word, lo_word} >> (8*off), take the low size bytes, and extend them per req_us; hi_word SHALL be 0 when the access is not split.
REQ-035 SHALL capture the low-phase read word in an internal register.

Reset
REQ-036 SHALL, on rst, immediately enter IDLE and force req_ready = 1 and all other outputs to 0, including sram_req, resp_valid and resp_err.
REQ-037 SHALL abandon any in-flight access when reset is asserted mid-operation, produce no resp_valid for it, and ignore SRAM responses that arrive after reset.

Configuration
REQ-038 SHALL, when macro LSU_MISALIGN_SPLIT_EN is defined, perform misaligned accesses as two SRAM phases with resp_err = 0.
REQ-039 SHALL, when LSU_MISALIGN_SPLIT_EN is not defined, send a misaligned access IDLE -> RESP with no SRAM request, resp_err = 1 and resp_rdata = 0; REQ_HI and WAIT_HI SHALL then be unreachable.
REQ-040 SHALL handle aligned accesses identically in both configurations.

Verification
REQ-041 SHALL cover: lb at 0x1003 with rdata 0x80112233, us = 0 -> a single phase, sram_addr 0x1000, resp_rdata 0xFFFFFF80 at cycle 3.
REQ-042 SHALL cover: sh at 0x2002 with wdata 0x0000BEEF -> sram_wstrb 1100, sram_wdata 0xBEEF0000, resp_err 0.
REQ-043 SHALL cover, split enabled: lw at 0x3001, lo word 0xAABBCCDD, hi word 0x11223344 -> addresses 0x3000 then 0x3004, resp_rdata 0x44AABBCC.
REQ-044 SHALL cover, split enabled: sw at 0xFFFFFFFE with wdata 0x12345678 -> phase 1 at 0xFFFFFFFC with wstrb 1100 and wdata 0x56780000, phase 2 at 0x00000000 with wstrb 0011 and wdata 0x00001234.
REQ-045 SHALL cover, split disabled: lh at 0x4003 -> no sram_req, resp_valid with resp_err = 1 at cycle 1.
REQ-046 SHALL cover: sram_gnt held low for 5 cycles, then rst asserted in WAIT_LO -> stable request outputs while ungranted, no resp_valid, and IDLE with req_ready = 1 after reset.
